// File: rtl/alg_apb_arb_pkg.sv
// Shared types and constants for the round-robin APB arbiter.
package alg_apb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_END    = 2'd3
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/alg_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module alg_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    // i runs 1..NUM_REQ so 'last' itself is considered only after all others
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/alg_apb_rr_arbiter.sv
// Shares one APB completer among NUM_REQ APB requesters, round-robin, one transfer at a time.
// Optional ACCESS-phase timeout enabled by defining ALG_APB_ARB_TIMEOUT_EN.
module alg_apb_rr_arbiter
  import alg_apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           s_sel,
  input  logic [NUM_REQ-1:0]           s_enable,
  input  logic [NUM_REQ-1:0]           s_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
  input  logic [NUM_REQ*32-1:0]        s_wdata,
  output logic [NUM_REQ-1:0]           s_ready,
  output logic [NUM_REQ*32-1:0]        s_rdata,
  output logic [NUM_REQ-1:0]           s_slverr,
  output logic                         m_sel,
  output logic                         m_enable,
  output logic                         m_write,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic [31:0]                  m_wdata,
  input  logic                         m_ready,
  input  logic [31:0]                  m_rdata,
  input  logic                         m_slverr,
  output logic [$clog2(NUM_REQ)-1:0]   grant,
  output logic                         busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("alg_apb_rr_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("alg_apb_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e               state_q, state_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic [GW-1:0]            grant_d;
  logic                     m_sel_d, m_enable_d, m_write_d;
  logic [ADDR_WIDTH-1:0]    m_addr_d;
  logic [31:0]              m_wdata_d;
  logic [NUM_REQ-1:0]       s_ready_d, s_slverr_d;
  logic [NUM_REQ*32-1:0]    s_rdata_d;
  logic [GW-1:0]            pick_idx;
  logic                     pick_valid;
  logic                     done;
  logic [31:0]              done_rdata;
  logic                     done_err;

`ifdef ALG_APB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  alg_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req    (s_sel),
    .last   (last_grant_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant        <= '0;
      m_sel        <= 1'b0;
      m_enable     <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      s_ready      <= '0;
      s_slverr     <= '0;
      s_rdata      <= '0;
`ifdef ALG_APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant        <= grant_d;
      m_sel        <= m_sel_d;
      m_enable     <= m_enable_d;
      m_write      <= m_write_d;
      m_addr       <= m_addr_d;
      m_wdata      <= m_wdata_d;
      s_ready      <= s_ready_d;
      s_slverr     <= s_slverr_d;
      s_rdata      <= s_rdata_d;
`ifdef ALG_APB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant;
    m_sel_d      = m_sel;
    m_enable_d   = m_enable;
    m_write_d    = m_write;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    s_ready_d    = s_ready;
    s_slverr_d   = s_slverr;
    s_rdata_d    = s_rdata;
    done         = 1'b0;
    done_rdata   = m_rdata;
    done_err     = m_slverr;
`ifdef ALG_APB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          m_sel_d   = 1'b1;
          m_write_d = s_write[pick_idx];
          m_addr_d  = s_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_d = s_wdata[pick_idx*32 +: 32];
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        // A withdrawn request leaves last_grant untouched so the port keeps its turn
        if (!s_sel[grant]) begin
          m_sel_d = 1'b0;
          state_d = S_IDLE;
        end else if (s_enable[grant]) begin
          m_enable_d = 1'b1;
          state_d    = S_ACCESS;
`ifdef ALG_APB_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (m_ready) begin
          done = 1'b1;
        end
`ifdef ALG_APB_ARB_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          done       = 1'b1;
          done_rdata = TIMEOUT_RDATA;
          done_err   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_END: begin
        s_ready_d  = '0;
        s_slverr_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      m_sel_d                 = 1'b0;
      m_enable_d              = 1'b0;
      s_ready_d[grant]        = 1'b1;
      s_slverr_d[grant]       = done_err;
      s_rdata_d[grant*32 +: 32] = done_rdata;
      last_grant_d            = grant;
      state_d                 = S_END;
    end
  end

endmodule

// File: tb/tb_alg_apb_rr_arbiter.sv
// Directed self-checking bench for alg_apb_rr_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_alg_apb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 22;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_sel, s_enable, s_write;
  logic [N*AW-1:0] s_addr;
  logic [N*32-1:0] s_wdata;
  logic [N-1:0]    s_ready, s_slverr;
  logic [N*32-1:0] s_rdata;
  logic            m_sel, m_enable, m_write;
  logic [AW-1:0]   m_addr;
  logic [31:0]     m_wdata;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic            m_slverr;
  logic [1:0]      grant;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Downstream completer returns 0x100 + address on reads
  assign m_rdata = 32'h100 + {10'd0, m_addr};

  always #5 clk = ~clk;

  alg_apb_rr_arbiter #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_sel    (s_sel),
    .s_enable (s_enable),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_slverr (s_slverr),
    .m_sel    (m_sel),
    .m_enable (m_enable),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_slverr (m_slverr),
    .grant    (grant),
    .busy     (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    s_sel[i]          = 1'b1;
    s_enable[i]       = 1'b0;
    s_write[i]        = wr;
    s_addr[i*AW +: AW] = a;
    s_wdata[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs;
    s_sel    = '0;
    s_enable = '0;
  endtask

  task automatic settle;
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; s_sel = '0; s_enable = '0; s_write = '0; s_addr = '0; s_wdata = '0;
    m_ready = 1'b0; m_slverr = 1'b0;
    #2 rst = 1'b1;
    #2;
    n_checks++;
    if ({m_sel, m_enable, m_write, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {m_sel, m_enable, m_write, busy});
    end
    n_checks++;
    if ({m_addr, m_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mbus: got addr %h wdata %h required 0", m_addr, m_wdata);
    end
    n_checks++;
    if ({s_ready, s_slverr, s_rdata, grant} !== '0) begin
      n_fail++; $display("FAIL reset_sports: got ready %b slverr %b grant %0d required 0", s_ready, s_slverr, grant);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write;
    int lat;
    set_req(2, 1'b1, 22'h001234, 32'hA5A5_0001);
    m_ready = 1'b1;
    lat = 1;
    tick();
    lat++;
    n_checks++;
    if ({m_sel, m_write, m_addr, m_wdata, grant} !== {1'b1, 1'b1, 22'h001234, 32'hA5A5_0001, 2'd2}) begin
      n_fail++; $display("FAIL single_setup: got sel %b wr %b addr %h wdata %h grant %0d required 1 1 001234 a5a50001 2",
                         m_sel, m_write, m_addr, m_wdata, grant);
    end
    s_enable[2] = 1'b1;
    while (s_ready == '0 && lat < 12) begin
      tick();
      lat++;
    end
    // Cycle of s_sel presentation counts as cycle 1
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles required 4", lat);
    end
    n_checks++;
    if ({s_ready, m_sel, m_enable} !== {4'b0100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_ready: got ready %b sel %b en %b required 0100 0 0", s_ready, m_sel, m_enable);
    end
    clear_reqs();
    tick();
    n_checks++;
    if ({s_ready, busy} !== 5'b0) begin
      n_fail++; $display("FAIL single_pulse: got ready %b busy %b required 0000 0", s_ready, busy);
    end
    settle();
  endtask

  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int w;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i), 32'h0);
    s_enable = 4'hF;
    m_ready  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (s_ready == '0 && w < 8);
      n_checks++;
      if (s_ready !== 4'(1 << exp_seq[j]) || grant !== 2'(exp_seq[j])) begin
        n_fail++; $display("FAIL rr_order[%0d]: got ready %b grant %0d required port %0d", j, s_ready, grant, exp_seq[j]);
      end
      n_checks++;
      if (s_rdata[exp_seq[j]*32 +: 32] !== 32'h100 + 32'(exp_seq[j])) begin
        n_fail++; $display("FAIL rr_rdata[%0d]: got %h required %h", j, s_rdata[exp_seq[j]*32 +: 32], 32'h100 + 32'(exp_seq[j]));
      end
    end
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s_rdata[i*32 +: 32] !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL rr_hold[%0d]: got %h required %h", i, s_rdata[i*32 +: 32], 32'h100 + 32'(i));
      end
    end
    settle();
  endtask

  task automatic test_withdraw;
    set_req(1, 1'b0, 22'h11, 32'h0);
    m_ready = 1'b1;
    tick();
    n_checks++;
    if ({m_sel, grant} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL wd_grant: got sel %b grant %0d required 1 1", m_sel, grant);
    end
    s_sel[1] = 1'b0;
    tick();
    n_checks++;
    if ({m_sel, s_ready, busy} !== 6'b0) begin
      n_fail++; $display("FAIL wd_drop: got sel %b ready %b busy %b required 0 0000 0", m_sel, s_ready, busy);
    end
    set_req(1, 1'b0, 22'h11, 32'h0);
    set_req(2, 1'b0, 22'h22, 32'h0);
    tick();
    n_checks++;
    if (grant !== 2'd1) begin
      n_fail++; $display("FAIL wd_regrant: got %0d required 1", grant);
    end
    s_enable[1] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_ready !== 4'b0010) begin
      n_fail++; $display("FAIL wd_ready1: got %b required 0010", s_ready);
    end
    s_sel[1] = 1'b0; s_enable[1] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (grant !== 2'd2) begin
      n_fail++; $display("FAIL wd_loser: got %0d required 2", grant);
    end
    s_enable[2] = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({s_ready, s_rdata[2*32 +: 32]} !== {4'b0100, 32'h122}) begin
      n_fail++; $display("FAIL wd_ready2: got ready %b rdata %h required 0100 00000122", s_ready, s_rdata[2*32 +: 32]);
    end
    settle();
  endtask

  task automatic test_wait_states;
    int en;
    logic early;
    set_req(3, 1'b1, 22'h33, 32'h3333);
    m_ready = 1'b0; m_slverr = 1'b0;
    tick();
    s_enable[3] = 1'b1;
    tick();
    en = m_enable ? 1 : 0;
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_enable) en++;
      if (s_ready != '0) early = 1'b1;
    end
    m_ready = 1'b1; m_slverr = 1'b1;
    tick();
    n_checks++;
    if (en !== 11 || early !== 1'b0) begin
      n_fail++; $display("FAIL ws_enable: got %0d enable cycles early_ready %b required 11 0", en, early);
    end
    n_checks++;
    if ({s_ready, s_slverr, m_enable} !== {4'b1000, 4'b1000, 1'b0}) begin
      n_fail++; $display("FAIL ws_done: got ready %b slverr %b en %b required 1000 1000 0", s_ready, s_slverr, m_enable);
    end
    clear_reqs();
    m_slverr = 1'b0;
    tick();
    n_checks++;
    if ({s_ready, s_slverr} !== 8'b0) begin
      n_fail++; $display("FAIL ws_clear: got ready %b slverr %b required 0", s_ready, s_slverr);
    end
    settle();
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b1, 22'h44, 32'h4444);
    m_ready = 1'b0;
    tick();
    s_enable[1] = 1'b1;
    tick();
    n_checks++;
    if (m_enable !== 1'b1) begin
      n_fail++; $display("FAIL rm_access: got en %b required 1", m_enable);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_sel, m_enable, busy, grant, s_ready, s_slverr} !== '0 || s_rdata !== '0) begin
      n_fail++; $display("FAIL rm_async: got sel %b en %b busy %b grant %0d ready %b required all 0",
                         m_sel, m_enable, busy, grant, s_ready);
    end
    #1 rst = 1'b0;
    clear_reqs();
    set_req(3, 1'b0, 22'h3, 32'h0);
    set_req(0, 1'b0, 22'h0, 32'h0);
    tick();
    n_checks++;
    if ({m_sel, grant} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL rm_first: got sel %b grant %0d required 1 0", m_sel, grant);
    end
    s_enable[0] = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rm_ready: got %b required 0001", s_ready);
    end
    settle();
  endtask

  task automatic test_timeout;
    int en;
    int w;
    set_req(2, 1'b0, 22'h55, 32'h0);
    m_ready = 1'b0;
    tick();
    s_enable[2] = 1'b1;
    tick();
    en = m_enable ? 1 : 0;
    w = 0;
    while (s_ready == '0 && w < 40) begin
      tick();
      w++;
      if (m_enable) en++;
    end
`ifdef ALG_APB_ARB_TIMEOUT_EN
    n_checks++;
    if (en !== 16) begin
      n_fail++; $display("FAIL to_cycles: got %0d enable cycles required 16", en);
    end
    n_checks++;
    if ({s_ready, s_slverr, m_sel, m_enable} !== {4'b0100, 4'b0100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL to_resp: got ready %b slverr %b sel %b en %b required 0100 0100 0 0",
                         s_ready, s_slverr, m_sel, m_enable);
    end
    n_checks++;
    if (s_rdata[2*32 +: 32] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL to_rdata: got %h required deadbeef", s_rdata[2*32 +: 32]);
    end
`else
    n_checks++;
    if ({w == 40, busy, m_enable, s_ready} !== {3'b111, 4'b0000}) begin
      n_fail++; $display("FAIL to_stuck: got waited %0d busy %b en %b ready %b required 40 1 1 0000",
                         w, busy, m_enable, s_ready);
    end
    m_ready = 1'b1;
    tick();
    n_checks++;
    if ({s_ready, s_slverr, s_rdata[2*32 +: 32]} !== {4'b0100, 4'b0000, 32'h155}) begin
      n_fail++; $display("FAIL to_release: got ready %b slverr %b rdata %h required 0100 0000 00000155",
                         s_ready, s_slverr, s_rdata[2*32 +: 32]);
    end
`endif
    settle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_withdraw();
    test_wait_states();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alg_apb_rr_arbiter.md
Name: alg_apb_rr_arbiter

Overview:
- N-requester APB arbiter that shares one downstream APB completer among NUM_REQ APB requesters.
- Grants are round-robin and one transfer is serialised at a time.
- Each requester port behaves as an APB completer: it holds the requester's PREADY low until the downstream transfer finishes, then returns rdata and slverr.
- Sits in the DCD testbench/fabric where several APB masters (CPU model, DMA cfg, debug) reach a single register bank.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
ADDR_WIDTH, 22, APB address width
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with ALG_APB_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
s_sel  in  NUM_REQ  per-requester PSEL
s_enable  in  NUM_REQ  per-requester PENABLE
s_write  in  NUM_REQ  per-requester PWRITE
s_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
s_wdata  in  NUM_REQ*32  packed write data
s_ready  out  NUM_REQ  per-requester PREADY
s_rdata  out  NUM_REQ*32  packed read data
s_slverr  out  NUM_REQ  per-requester PSLVERR
m_sel  out  1  downstream PSEL
m_enable  out  1  downstream PENABLE
m_write  out  1  downstream PWRITE
m_addr  out  ADDR_WIDTH  downstream PADDR
m_wdata  out  32  downstream PWDATA
m_ready  in  1  downstream PREADY
m_rdata  in  32  downstream PRDATA
m_slverr  in  1  downstream PSLVERR
grant  out  $clog2(NUM_REQ)  index of requester currently or last served
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- All outputs are 0; state = IDLE.
- Internal last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transfer aborts immediately: m_sel/m_enable drop, no s_ready is issued, and the requester must restart.

IDLE:
- If any s_sel is set, grant the first set bit scanning (last_grant+1) mod NUM_REQ upward with wrap.
- Register m_write, m_addr, m_wdata from the granted port; set m_sel=1, grant=idx, go to SETUP.
- m_sel rises 1 cycle after s_sel is sampled.

SETUP:
- If s_sel[grant]=0 (requester withdrew): m_sel<=0, go to IDLE, no ready, last_grant unchanged.
- Else if s_enable[grant]=1: m_enable<=1, go to ACCESS.
- Else hold.

ACCESS:
- When m_ready=1: m_sel<=0, m_enable<=0, s_ready[grant]<=1, s_rdata[grant]<=m_rdata, s_slverr[grant]<=m_slverr, last_grant<=grant, go to END.
- rdata is captured on writes as well; requesters ignore it.

END:
- Clear all s_ready/s_slverr, go to IDLE.
- s_ready is a single-cycle pulse.
- s_rdata holds its value until the next completion on that port.

Arbitration and timing:
- Minimum requester-visible latency is 4 cycles from s_sel sampled to s_ready high, with zero-wait m_ready.
- Back-to-back bus occupancy is at least 4 cycles per transfer.
- Requests arriving while busy wait. Losers are never dropped, only delayed.
- Worst-case wait is NUM_REQ-1 transfers.
- Simultaneous requests in IDLE resolve purely by round-robin order; no fixed priority.
- Ports not granted see s_ready=0 throughout.

Optional Feature:
Macro ALG_APB_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on ACCESS entry and increments each ACCESS cycle while m_ready=0.
  - On reaching TIMEOUT_CYCLES-1 with m_ready still 0: drop m_sel/m_enable, pulse s_ready[grant] with s_slverr[grant]=1 and s_rdata[grant]=32'hDEAD_BEEF, update last_grant, go to END.
  - If m_ready=1 in the same cycle the limit is reached, the normal completion wins.
- Not defined: no counter; ACCESS waits indefinitely and s_slverr reflects only m_slverr.

Decomposition:
- Package alg_apb_arb_pkg holds the state enum (S_IDLE, S_SETUP, S_ACCESS, S_END; logic [1:0]) and the constant TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module alg_rr_pick (combinational): inputs req vector and last index; outputs winner index and valid flag. It is reusable by other arbiters.

Test Plan:
1. NUM_REQ=4, only s_sel[2]: write addr 0x00_1234, wdata 0xA5A5_0001, m_ready tied 1 -> m_addr=0x1234, m_write=1, s_ready[2] pulses 4 cycles after s_sel sampled, grant=2.
2. All four s_sel asserted together and held, reads with m_rdata=0x100+idx -> service order 0,1,2,3,0; s_rdata[i]=0x100+i; no port ready twice before all others are served.
3. Requester 1 drops s_sel in SETUP -> m_sel falls next cycle, no s_ready[1], next grant is still requester 1 if it re-requests alongside 2.
4. m_ready held 0 for 10 ACCESS cycles, then 1 with m_slverr=1 -> m_enable high 11 cycles, s_slverr[grant]=1 for one cycle with s_ready.
5. rst pulsed during ACCESS -> all outputs 0 asynchronously; after release, with s_sel[3] and s_sel[0] both set, requester 0 is granted.
6. With ALG_APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_ready stuck 0 -> s_ready pulses with slverr=1, rdata=0xDEAD_BEEF, m_sel low; an arbiter without the macro stays in ACCESS.
